vga_timing_ctrl: RTL and testbench

Sequences the VGA output pins (4-bit r/g/b, hSync, vSync) of the SoC peripheral domain. Generates horizontal and vertical timing from parameterised counters and pulls pixels from a valid/ready pixel stream only during the active region. Provides frame-start and underflow status for the framebuffer/DMA front-end. Runs in the system clock domain; the pixel clock equals io_clock.

---
 rtl/vga_timing_ctrl_if.sv | 31 +++
 rtl/vga_timing_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_vga_timing_ctrl.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/vga_timing_ctrl_if.sv
// Pixel stream, control/status and VGA pin bundle for vga_timing_ctrl.
// master = stream/framebuffer side, slave = the timing controller.
interface vga_timing_ctrl_if;
  logic        io_enable;
  logic        io_pixel_valid;
  logic        io_pixel_ready;
  logic [11:0] io_pixel_data;
  logic        io_clearUnderflow;
  logic        io_underflow;
  logic        io_frameStart;
  logic        io_busy;
  logic [3:0]  io_vga_pixels_r;
  logic [3:0]  io_vga_pixels_g;
  logic [3:0]  io_vga_pixels_b;
  logic        io_vga_hSync;
  logic        io_vga_vSync;

  modport master (
    output io_enable, io_pixel_valid, io_pixel_data, io_clearUnderflow,
    input  io_pixel_ready, io_underflow, io_frameStart, io_busy,
    input  io_vga_pixels_r, io_vga_pixels_g, io_vga_pixels_b,
    input  io_vga_hSync, io_vga_vSync
  );

  modport slave (
    input  io_enable, io_pixel_valid, io_pixel_data, io_clearUnderflow,
    output io_pixel_ready, io_underflow, io_frameStart, io_busy,
    output io_vga_pixels_r, io_vga_pixels_g, io_vga_pixels_b,
    output io_vga_hSync, io_vga_vSync
  );
endinterface

// File: rtl/vga_timing_ctrl.sv
// VGA timing generator: h/v counters, run/stop sequencing, pixel stream pull
// during the active region and a one-cycle-latency registered pin stage.
module vga_timing_ctrl #(
  parameter int   H_ACTIVE  = 640,
  parameter int   H_FP      = 16,
  parameter int   H_SYNC    = 96,
  parameter int   H_BP      = 48,
  parameter int   V_ACTIVE  = 480,
  parameter int   V_FP      = 10,
  parameter int   V_SYNC    = 2,
  parameter int   V_BP      = 33,
  parameter logic SYNC_POL  = 1'b0,
  parameter int   CNT_WIDTH = 11
) (
  input logic              io_clock,
  input logic              io_reset,
  vga_timing_ctrl_if.slave vga
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int CW1     = CNT_WIDTH + 1;

  localparam logic [CNT_WIDTH-1:0] CNT_ZERO = CNT_WIDTH'(0);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] H_LAST   = CNT_WIDTH'(H_TOTAL - 1);
  localparam logic [CNT_WIDTH-1:0] V_LAST   = CNT_WIDTH'(V_TOTAL - 1);
  // One bit wider so a sync end equal to 2^CNT_WIDTH still compares correctly.
  localparam logic [CW1-1:0] H_ACT_W   = CW1'(H_ACTIVE);
  localparam logic [CW1-1:0] H_SYNC_LO = CW1'(H_ACTIVE + H_FP);
  localparam logic [CW1-1:0] H_SYNC_HI = CW1'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW1-1:0] V_ACT_W   = CW1'(V_ACTIVE);
  localparam logic [CW1-1:0] V_SYNC_LO = CW1'(V_ACTIVE + V_FP);
  localparam logic [CW1-1:0] V_SYNC_HI = CW1'(V_ACTIVE + V_FP + V_SYNC);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RUN      = 2'd1,
    ST_STOPPING = 2'd2
  } state_t;

  state_t               state_r;
  logic [CNT_WIDTH-1:0] h_cnt_r;
  logic [CNT_WIDTH-1:0] v_cnt_r;
  logic [3:0]           red_r;
  logic [3:0]           green_r;
  logic [3:0]           blue_r;
  logic                 hsync_r;
  logic                 vsync_r;
  logic                 frame_start_r;
  logic                 underflow_r;
  logic                 busy_r;

  logic [CNT_WIDTH-1:0] h_nxt_s;
  logic [CNT_WIDTH-1:0] v_nxt_s;
  logic                 running_s;
  logic                 active_s;
  logic                 ready_s;
  logic                 transfer_s;
  logic                 frame_end_s;
  logic                 hsync_on_s;
  logic                 vsync_on_s;

  // Region decode and counter successor from the registered counters/state.
  always_comb begin
    running_s   = (state_r != ST_IDLE);
    frame_end_s = (h_cnt_r == H_LAST) && (v_cnt_r == V_LAST);
    active_s    = running_s && ({1'b0, h_cnt_r} < H_ACT_W) && ({1'b0, v_cnt_r} < V_ACT_W);
    ready_s     = active_s && !io_reset;
    transfer_s  = ready_s && vga.io_pixel_valid;
    hsync_on_s  = ({1'b0, h_cnt_r} >= H_SYNC_LO) && ({1'b0, h_cnt_r} < H_SYNC_HI);
    vsync_on_s  = ({1'b0, v_cnt_r} >= V_SYNC_LO) && ({1'b0, v_cnt_r} < V_SYNC_HI);
    if (h_cnt_r == H_LAST) begin
      h_nxt_s = CNT_ZERO;
      if (v_cnt_r == V_LAST) begin
        v_nxt_s = CNT_ZERO;
      end else begin
        v_nxt_s = v_cnt_r + CNT_ONE;
      end
    end else begin
      h_nxt_s = h_cnt_r + CNT_ONE;
      v_nxt_s = v_cnt_r;
    end
  end

  // Run/stop FSM, counters and the registered pin/status stage.
  always_ff @(posedge io_clock) begin
    if (io_reset) begin
      state_r       <= ST_IDLE;
      h_cnt_r       <= CNT_ZERO;
      v_cnt_r       <= CNT_ZERO;
      red_r         <= 4'h0;
      green_r       <= 4'h0;
      blue_r        <= 4'h0;
      hsync_r       <= ~SYNC_POL;
      vsync_r       <= ~SYNC_POL;
      frame_start_r <= 1'b0;
      underflow_r   <= 1'b0;
      busy_r        <= 1'b0;
    end else begin
      // busy_r is loaded with the next state so it always mirrors state_r.
      case (state_r)
        ST_IDLE: begin
          h_cnt_r <= CNT_ZERO;
          v_cnt_r <= CNT_ZERO;
          if (vga.io_enable) begin
            state_r <= ST_RUN;
            busy_r  <= 1'b1;
          end else begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
          end
        end
        ST_RUN: begin
          h_cnt_r <= h_nxt_s;
          v_cnt_r <= v_nxt_s;
          busy_r  <= 1'b1;
          if (vga.io_enable) begin
            state_r <= ST_RUN;
          end else begin
            state_r <= ST_STOPPING;
          end
        end
        ST_STOPPING: begin
          h_cnt_r <= h_nxt_s;
          v_cnt_r <= v_nxt_s;
          if (vga.io_enable) begin
            state_r <= ST_RUN;
            busy_r  <= 1'b1;
          end else if (frame_end_s) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
          end else begin
            state_r <= ST_STOPPING;
            busy_r  <= 1'b1;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          h_cnt_r <= CNT_ZERO;
          v_cnt_r <= CNT_ZERO;
          busy_r  <= 1'b0;
        end
      endcase

      if (running_s) begin
        red_r         <= transfer_s ? vga.io_pixel_data[11:8] : 4'h0;
        green_r       <= transfer_s ? vga.io_pixel_data[7:4]  : 4'h0;
        blue_r        <= transfer_s ? vga.io_pixel_data[3:0]  : 4'h0;
        hsync_r       <= hsync_on_s ? SYNC_POL : ~SYNC_POL;
        vsync_r       <= vsync_on_s ? SYNC_POL : ~SYNC_POL;
        frame_start_r <= (h_cnt_r == CNT_ZERO) && (v_cnt_r == CNT_ZERO);
      end else begin
        red_r         <= 4'h0;
        green_r       <= 4'h0;
        blue_r        <= 4'h0;
        hsync_r       <= ~SYNC_POL;
        vsync_r       <= ~SYNC_POL;
        frame_start_r <= 1'b0;
      end

      // A new underflow outranks a simultaneous clear.
      if (active_s && !vga.io_pixel_valid) begin
        underflow_r <= 1'b1;
      end else if (vga.io_clearUnderflow) begin
        underflow_r <= 1'b0;
      end else begin
        underflow_r <= underflow_r;
      end
    end
  end

  assign vga.io_pixel_ready  = ready_s;
  assign vga.io_underflow    = underflow_r;
  assign vga.io_frameStart   = frame_start_r;
  assign vga.io_busy         = busy_r;
  assign vga.io_vga_pixels_r = red_r;
  assign vga.io_vga_pixels_g = green_r;
  assign vga.io_vga_pixels_b = blue_r;
  assign vga.io_vga_hSync    = hsync_r;
  assign vga.io_vga_vSync    = vsync_r;
endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Directed/randomised bench for vga_timing_ctrl against a frame-position
// reference model (small 15x7 raster, active-low syncs).
module tb_vga_timing_ctrl;
  localparam int HA = 8, HF = 2, HS = 3, HB = 2;
  localparam int VA = 4, VF = 1, VS = 1, VB = 1;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FT = HT * VT;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  vga_timing_ctrl_if vif();

  vga_timing_ctrl #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .SYNC_POL(1'b0), .CNT_WIDTH(11)
  ) dut (
    .io_clock(clk),
    .io_reset(rst),
    .vga(vif)
  );

  int n_pass = 0;
  int n_checks = 0;
  int tick_no = 0;

  // model: state 0=idle 1=run 2=stopping, pos = linear position in frame
  int m_state = 0;
  int m_pos = 0;
  logic [11:0] e_rgb = 12'h000;
  logic e_hs = 1'b1, e_vs = 1'b1, e_fs = 1'b0, e_uf = 1'b0, e_busy = 1'b0;

  int vs_low, hs_low, pix_abc, fs_cnt, ready_seen;
  int last_fs = -1;
  bit chk_period = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h (tick %0d)", tag, obs, exp, tick_no);
  endtask

  task automatic tick();
    int h, v;
    logic act, ready_e, xfer;
    #2;
    h = m_pos % HT;
    v = m_pos / HT;
    act = (m_state != 0) && (h < HA) && (v < VA);
    ready_e = act && !rst;
    chk("ready", 32'(vif.io_pixel_ready), 32'(ready_e));
    if (vif.io_pixel_ready === 1'b1) ready_seen++;
    if (rst) begin
      m_state = 0; m_pos = 0;
      e_rgb = 12'h000; e_hs = 1'b1; e_vs = 1'b1; e_fs = 1'b0; e_uf = 1'b0;
    end else begin
      xfer = ready_e && vif.io_pixel_valid;
      if (m_state == 0) begin
        e_rgb = 12'h000; e_hs = 1'b1; e_vs = 1'b1; e_fs = 1'b0;
      end else begin
        e_rgb = xfer ? vif.io_pixel_data : 12'h000;
        e_hs  = !((h >= HA + HF) && (h < HA + HF + HS));
        e_vs  = !((v >= VA + VF) && (v < VA + VF + VS));
        e_fs  = (m_pos == 0);
      end
      if (act && !vif.io_pixel_valid) e_uf = 1'b1;
      else if (vif.io_clearUnderflow) e_uf = 1'b0;
      if (m_state == 0) begin
        if (vif.io_enable) m_state = 1;
      end else begin
        if (vif.io_enable) m_state = 1;
        else if (m_state == 2 && m_pos == FT - 1) m_state = 0;
        else m_state = 2;
        m_pos = (m_pos + 1) % FT;
      end
    end
    e_busy = (m_state != 0);
    @(posedge clk);
    #1;
    tick_no++;
    chk("rgb", 32'({vif.io_vga_pixels_r, vif.io_vga_pixels_g, vif.io_vga_pixels_b}), 32'(e_rgb));
    chk("hsync", 32'(vif.io_vga_hSync), 32'(e_hs));
    chk("vsync", 32'(vif.io_vga_vSync), 32'(e_vs));
    chk("frame_start", 32'(vif.io_frameStart), 32'(e_fs));
    chk("underflow", 32'(vif.io_underflow), 32'(e_uf));
    chk("busy", 32'(vif.io_busy), 32'(e_busy));
    if (vif.io_vga_vSync === 1'b0) vs_low++;
    if (vif.io_vga_hSync === 1'b0) hs_low++;
    if ({vif.io_vga_pixels_r, vif.io_vga_pixels_g, vif.io_vga_pixels_b} === 12'hABC) pix_abc++;
    if (vif.io_frameStart === 1'b1) begin
      fs_cnt++;
      if (chk_period && last_fs >= 0) chk("fs_period", 32'(tick_no - last_fs), 32'(FT));
      last_fs = tick_no;
    end
  endtask

  task automatic run_until(input int target);
    for (int i = 0; i < 2 * FT && m_pos != target; i++) tick();
    chk("reach_pos", 32'(m_pos), 32'(target));
  endtask

  task automatic clear_stats();
    vs_low = 0; hs_low = 0; pix_abc = 0; fs_cnt = 0; ready_seen = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    vif.io_enable = 1'b0;
    vif.io_pixel_valid = 1'b0;
    vif.io_pixel_data = 12'h000;
    vif.io_clearUnderflow = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    repeat (2) tick();

    // Steady run with a constant pixel.
    clear_stats();
    vif.io_enable = 1'b1;
    vif.io_pixel_valid = 1'b1;
    vif.io_pixel_data = 12'hABC;
    repeat (1 + 2 * FT) tick();
    chk("s1_vsync_low", 32'(vs_low), 32'(2 * HT * VS));
    chk("s1_hsync_low", 32'(hs_low), 32'(2 * VT * HS));
    chk("s1_abc_pixels", 32'(pix_abc), 32'(2 * HA * VA));
    chk("s1_frame_starts", 32'(fs_cnt), 32'(2));

    // Underflow set, sticky, clear, and set-beats-clear.
    vif.io_pixel_valid = 1'b0;
    tick();
    vif.io_pixel_valid = 1'b1;
    repeat (20) tick();
    chk("s2_uf_sticky", 32'(vif.io_underflow), 32'(1));
    vif.io_clearUnderflow = 1'b1;
    tick();
    vif.io_clearUnderflow = 1'b0;
    tick();
    chk("s2_uf_cleared", 32'(vif.io_underflow), 32'(0));
    run_until(HT + 3);
    vif.io_pixel_valid = 1'b0;
    vif.io_clearUnderflow = 1'b1;
    tick();
    vif.io_pixel_valid = 1'b1;
    vif.io_clearUnderflow = 1'b0;
    chk("s2_set_wins", 32'(vif.io_underflow), 32'(1));
    repeat (5) tick();

    // Toggling valid with random data, then fully random valid.
    run_until(0);
    clear_stats();
    for (int i = 0; i < FT; i++) begin
      vif.io_pixel_valid = ~vif.io_pixel_valid;
      vif.io_pixel_data = 12'($urandom);
      tick();
    end
    chk("s6_ready_per_frame", 32'(ready_seen), 32'(HA * VA));
    for (int i = 0; i < FT; i++) begin
      vif.io_pixel_valid = 1'($urandom_range(0, 1));
      vif.io_pixel_data = 12'($urandom);
      vif.io_clearUnderflow = 1'($urandom_range(0, 1));
      tick();
    end
    vif.io_clearUnderflow = 1'b0;
    vif.io_pixel_valid = 1'b1;

    // Stop mid-frame: frame completes, then idle.
    run_until(2 * HT + 5);
    vif.io_enable = 1'b0;
    repeat (FT) tick();
    chk("s3_idle_busy", 32'(vif.io_busy), 32'(0));
    repeat (10) tick();
    chk("s3_idle_hsync", 32'(vif.io_vga_hSync), 32'(1));
    chk("s3_idle_ready", 32'(vif.io_pixel_ready), 32'(0));

    // Stop then resume inside one frame: frame cadence unbroken.
    vif.io_enable = 1'b1;
    run_until(50);
    vif.io_enable = 1'b0;
    repeat (5) tick();
    vif.io_enable = 1'b1;
    chk_period = 1'b1;
    last_fs = -1;
    repeat (2 * FT + 5) tick();
    chk_period = 1'b0;

    // Reset mid-frame with enable held.
    run_until(HT + 9);
    rst = 1'b1;
    tick();
    chk("s5_busy_reset", 32'(vif.io_busy), 32'(0));
    chk("s5_vsync_reset", 32'(vif.io_vga_vSync), 32'(1));
    rst = 1'b0;
    clear_stats();
    repeat (FT) tick();
    chk("s5_restart_fs", 32'(fs_cnt), 32'(1));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
